// File: rtl/inst_loader_ctrl_if.sv
// Bus between the instruction loader controller and the UART/IF/pipeline side.
// master: controller view; slave: environment view.
interface inst_loader_ctrl_if #(
    parameter int INST_SZ = 32,
    parameter int PC_SZ   = 32
);
    logic [7:0]         i_rx_data;
    logic               i_rx_valid;
    logic               i_halt;
    logic               o_write;
    logic               o_enable;
    logic [INST_SZ-1:0] o_instruction;
    logic [PC_SZ-1:0]   o_wr_addr;
    logic               o_done;
    logic               o_err;
    logic [2:0]         o_state;

    modport master (
        input  i_rx_data, i_rx_valid, i_halt,
        output o_write, o_enable, o_instruction, o_wr_addr,
        output o_done, o_err, o_state
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_halt,
        input  o_write, o_enable, o_instruction, o_wr_addr,
        input  o_done, o_err, o_state
    );
endinterface

// File: rtl/inst_loader_ctrl.sv
// Loads instruction words from a UART byte stream into IF, then gates execution.
// Optional single-step mode is compiled in when STEP_MODE_EN is defined.
module inst_loader_ctrl #(
    parameter int INST_SZ = 32,
    parameter int PC_SZ   = 32
) (
    input  logic i_clk,
    input  logic i_reset,
    inst_loader_ctrl_if.master bus
);
    localparam int NB    = INST_SZ / 8;
    localparam int IDX_W = $clog2(NB + 1);

    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_C = 8'h43;
`ifdef STEP_MODE_EN
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_N = 8'h4E;
    localparam logic [7:0] CMD_E = 8'h45;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CNT  = 3'd1,
        LOAD_BYTE = 3'd2,
        WRITE     = 3'd3,
        RUN       = 3'd4,
        STEP_WAIT = 3'd5,
        STEP_EXEC = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [INST_SZ-1:0] instr_q, instr_d;
    logic [PC_SZ-1:0]   addr_q, addr_d;
    logic               write_q, write_d;
    logic               enable_q, enable_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic       rx_v;
    logic [7:0] rx_b;

    assign rx_v = bus.i_rx_valid;
    assign rx_b = bus.i_rx_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            instr_q  <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // write/enable are computed here for the next state, so they are
    // mutually exclusive by construction and registered at the outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        write_d  = 1'b0;
        enable_d = 1'b0;
        done_d   = done_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (rx_v) begin
                    if (rx_b == CMD_L) begin
                        state_d = LOAD_CNT;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        addr_d  = '0;
                        idx_d   = '0;
                    end else if (rx_b == CMD_C) begin
                        state_d  = RUN;
                        enable_d = 1'b1;
                    end
`ifdef STEP_MODE_EN
                    else if (rx_b == CMD_S) begin
                        state_d = STEP_WAIT;
                    end
`endif
                end
            end
            LOAD_CNT: begin
                if (rx_v) begin
                    if (rx_b == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = rx_b;
                        idx_d   = '0;
                        state_d = LOAD_BYTE;
                    end
                end
            end
            LOAD_BYTE: begin
                if (rx_v) begin
                    instr_d = INST_SZ'({instr_q, rx_b});
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NB - 1)) begin
                        state_d = WRITE;
                        write_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (rx_v) begin
                    err_d = 1'b1;
                end
                addr_d = addr_q + PC_SZ'(4);
                cnt_d  = cnt_q - 8'd1;
                idx_d  = '0;
                if (cnt_q == 8'd1) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOAD_BYTE;
                end
            end
            RUN: begin
                if (bus.i_halt) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    enable_d = 1'b1;
                end
            end
`ifdef STEP_MODE_EN
            STEP_WAIT: begin
                if (rx_v) begin
                    if (rx_b == CMD_N) begin
                        state_d = STEP_EXEC;
                    end else if (rx_b == CMD_E) begin
                        state_d = IDLE;
                    end
                end
            end
            STEP_EXEC: begin
                if (bus.i_halt) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = STEP_WAIT;
                    enable_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_write       = write_q;
    assign bus.o_enable      = enable_q;
    assign bus.o_instruction = instr_q;
    assign bus.o_wr_addr     = addr_q;
    assign bus.o_done        = done_q;
    assign bus.o_err         = err_q;
    assign bus.o_state       = state_q;
endmodule

// File: doc/inst_loader_ctrl.md
# inst_loader_ctrl

Sequencing controller for the instruction-fetch stage. It receives a byte stream from the debug UART receiver, assembles instruction words and writes them into instruction memory through the IF write port. It then gates IF/pipeline execution in continuous or single-step mode until the pipeline reports a halt. It drives the IF write and enable controls, so IF never writes and executes at the same time.

## Interface
Parameters:
- INST_SZ, 32, instruction width in bits; must be a multiple of 8.
- PC_SZ, 32, write-address width in bits.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  received UART byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid while high.
- i_halt  in  1  halt instruction reached write-back; level, sampled each cycle.
- o_write  out  1  instruction-memory write strobe to IF i_write.
- o_enable  out  1  execution enable to IF/pipeline i_enable.
- o_instruction  out  INST_SZ  assembled word to IF i_instruction_F.
- o_wr_addr  out  PC_SZ  byte address of the current write.
- o_done  out  1  sticky "program halted" flag.
- o_err  out  1  sticky protocol-error flag.
- o_state  out  3  current state encoding, for debug.

## Operation
- Commands (byte value in IDLE): 'L' 0x4C load, 'C' 0x43 run continuous, 'S' 0x53 step mode. Any other byte in IDLE is ignored.
- States: IDLE=0, LOAD_CNT=1, LOAD_BYTE=2, WRITE=3, RUN=4, STEP_WAIT=5, STEP_EXEC=6.
- IDLE + 'L' -> LOAD_CNT. Clears o_done and o_err, sets o_wr_addr=0 and byte index=0.
- LOAD_CNT + byte N: N=0 -> IDLE with no writes; otherwise word counter=N -> LOAD_BYTE.
- LOAD_BYTE: bytes are shifted in MSB first. After byte INST_SZ/8, o_instruction holds the full word -> WRITE.
- WRITE: o_write=1 for exactly this one cycle. On exit, o_wr_addr += 4 (wraps mod 2^PC_SZ) and counter -= 1. Counter reaching 0 -> IDLE; otherwise -> LOAD_BYTE with byte index=0.
- An i_rx_valid during WRITE: the byte is dropped and o_err is set. The load still completes.
- IDLE + 'C' -> RUN. o_enable=1 every cycle in RUN.
- RUN + i_halt=1 -> IDLE; o_enable=0 from the next cycle and o_done=1. Bytes received in RUN are ignored.
- STEP_WAIT: 'N' 0x4E -> STEP_EXEC; 'E' 0x45 -> IDLE; other bytes ignored.
- STEP_EXEC: o_enable=1 for exactly one cycle, then -> STEP_WAIT. If i_halt=1 in STEP_EXEC -> IDLE with o_done=1.
- o_write and o_enable are never both 1. Both are registered outputs.
- 'C' or 'S' accepted with o_done=1: execution starts; o_done stays set until the next 'L'.

## Timing
- Reset values: state IDLE, o_write=0, o_enable=0, o_instruction=0, o_wr_addr=0, o_done=0, o_err=0, o_state=0. Reset mid-load or mid-run aborts immediately; the partial word is discarded.
- All outputs are registered. A state change on rising edge k is visible after edge k.
- Write latency: o_write is high in the cycle immediately after the edge that captured the last byte of a word.
- Halt latency: i_halt high at edge k gives o_enable=0 after edge k, so at most one enabled cycle follows the halt.
- Step: 'N' strobe at edge k gives o_enable=1 for the cycle between edges k+1 and k+2.
- Minimum byte spacing for loss-free loading is 2 cycles, which UART rates guarantee.

## Configuration
- STEP_MODE_EN defined: states STEP_WAIT and STEP_EXEC and the 'S', 'N' and 'E' commands are present.
- STEP_MODE_EN undefined: step logic is compiled out and 'S' in IDLE is ignored like any unknown byte. o_state never reads 5 or 6.

## Test plan
- Reset, then 'L', 0x02, then bytes 12 34 56 78 AA BB CC DD at 4-cycle spacing -> two o_write pulses: 0x12345678 @ addr 0 and 0xAABBCCDD @ addr 4. State ends IDLE; o_enable is 0 throughout.
- 'L', 0x00 -> no o_write, state returns to IDLE, o_err=0.
- 'C', then i_halt raised 20 cycles later -> o_enable high for exactly those cycles, low the cycle after halt is sampled; o_done=1, state IDLE.
- STEP_MODE_EN: 'S', 'N', 'N', 'E' -> exactly two single-cycle o_enable pulses, then IDLE. Without the macro, 'S' leaves state at IDLE.
- Byte strobe injected during WRITE -> o_err=1, the byte is dropped, remaining words load correctly. A following 'L' clears o_err.
- Assert i_reset mid-word (after 2 of 4 bytes) -> all outputs return to reset values asynchronously. A fresh 'L' load writes from addr 0.
